// File: rtl/alu_seq.sv
// alu_seq: sequential add/sub/mul/div unit with start/done handshake.
// Ports: clk, rst_n, start, a, b, func -> busy, done, out, overflow.
// Optional macro ALU_SEQ_DIV_EN compiles in the restoring divider.
module alu_seq #(
  parameter int width = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  input  logic [1:0]         func,
  output logic               busy,
  output logic               done,
  output logic [2*width-1:0] out,
  output logic               overflow
);

  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*width-1:0] out_q, out_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [2*width-1:0] acc_q, acc_d;
  logic [2*width-1:0] mcand_q, mcand_d;
  // multiplier bits (mul) or dividend/quotient bits (div)
  logic [width-1:0]   sh_q, sh_d;

  logic [width:0]     sum;
  logic [width:0]     diff;
  logic [2*width-1:0] acc_step;

`ifdef ALU_SEQ_DIV_EN
  logic [width-1:0]   rem_q, rem_d;
  logic [width-1:0]   b_q, b_d;
  logic               div_q, div_d;
  logic [width:0]     rem_sh;
  logic               ge;
  logic [width-1:0]   rem_nxt;
  logic [width-1:0]   quo_nxt;
`endif

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    acc_step = sh_q[0] ? acc_q + mcand_q : acc_q;
`ifdef ALU_SEQ_DIV_EN
    rem_sh  = {rem_q, sh_q[width-1]};
    ge      = (rem_sh >= {1'b0, b_q});
    rem_nxt = width'(ge ? rem_sh - {1'b0, b_q} : rem_sh);
    quo_nxt = {sh_q[width-2:0], ge};
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    sh_d    = sh_q;
`ifdef ALU_SEQ_DIV_EN
    rem_d   = rem_q;
    b_d     = b_q;
    div_d   = div_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (func)
            2'b00: begin
              out_d          = '0;
              out_d[width:0] = sum;
              ovf_d          = sum[width];
              done_d         = 1'b1;
            end
            2'b01: begin
              out_d            = '0;
              out_d[width-1:0] = diff[width-1:0];
              ovf_d            = diff[width];
              done_d           = 1'b1;
            end
            2'b10: begin
              state_d = RUN;
              cnt_d   = '0;
              acc_d   = '0;
              mcand_d = {{width{1'b0}}, a};
              sh_d    = b;
`ifdef ALU_SEQ_DIV_EN
              div_d   = 1'b0;
`endif
            end
            2'b11: begin
`ifdef ALU_SEQ_DIV_EN
              if (b == '0) begin
                out_d  = {a, {width{1'b1}}};
                ovf_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                state_d = RUN;
                cnt_d   = '0;
                rem_d   = '0;
                sh_d    = a;
                b_d     = b;
                div_d   = 1'b1;
              end
`else
              out_d  = '0;
              ovf_d  = 1'b1;
              done_d = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
`ifdef ALU_SEQ_DIV_EN
        if (div_q) begin
          rem_d = rem_nxt;
          sh_d  = quo_nxt;
        end else begin
          acc_d   = acc_step;
          mcand_d = {mcand_q[2*width-2:0], 1'b0};
          sh_d    = {1'b0, sh_q[width-1:1]};
        end
`else
        acc_d   = acc_step;
        mcand_d = {mcand_q[2*width-2:0], 1'b0};
        sh_d    = {1'b0, sh_q[width-1:1]};
`endif
        // last step: publish result from the step's next values
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          ovf_d   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
          out_d   = div_q ? {rem_nxt, quo_nxt} : acc_step;
`else
          out_d   = acc_step;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      sh_q    <= '0;
`ifdef ALU_SEQ_DIV_EN
      rem_q   <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      sh_q    <= sh_d;
`ifdef ALU_SEQ_DIV_EN
      rem_q   <= rem_d;
      b_q     <= b_d;
      div_q   <= div_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign out      = out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed stimulus with a scoreboard queue and
// a monitor that checks each done pulse against it.
module tb_alu_seq;

  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     func = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] out;
  logic           overflow;

  alu_seq #(.width(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .func(func),
    .busy(busy), .done(done),
    .out(out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] o;
    logic           v;
    int             c;
    string          n;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   e = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: out=%0d cyc=%0d", out, cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (out !== x.o || overflow !== x.v || cyc != x.c) begin
          errors++;
          $display("FAIL %s: out=%0d ovf=%0d cyc=%0d, expected out=%0d ovf=%0d cyc=%0d",
                   x.n, out, overflow, cyc, x.o, x.v, x.c);
        end
      end
    end
  end

  // Caller sits at a negedge; k = edges after capture until done.
  task automatic send(input string n, input logic [1:0] f,
                      input logic [W-1:0] x, input logic [W-1:0] y,
                      input int k, input logic [2*W-1:0] eo,
                      input logic ev, input bit push);
    exp_t t;
    start = 1'b1;
    func  = f;
    a     = x;
    b     = y;
    t.o = eo;
    t.v = ev;
    t.c = cyc + 1 + k;
    t.n = n;
    if (push) sb.push_back(t);
    @(posedge clk);
    #1;
    e     = cyc;
    start = 1'b0;
    a     = ~x;
    b     = ~y;
    func  = 2'b00;
  endtask

  task automatic run(input string n, input logic [1:0] f,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input int k, input logic [2*W-1:0] eo,
                     input logic ev);
    @(negedge clk);
    send(n, f, x, y, k, eo, ev, 1'b1);
    do @(negedge clk); while (cyc < e + k);
    chk({n, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    #1;
    chk("rst_out", int'(out), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("add_63_1", 2'b00, 6'd63, 6'd1, 0, 12'd64, 1'b1);
    run("add_20_22", 2'b00, 6'd20, 6'd22, 0, 12'd42, 1'b0);
    run("sub_5_9", 2'b01, 6'd5, 6'd9, 0, 12'd60, 1'b1);
    run("sub_9_5", 2'b01, 6'd9, 6'd5, 0, 12'd4, 1'b0);

    // mul 63x63 with an ignored start while busy
    @(negedge clk);
    send("mul_63_63", 2'b10, 6'd63, 6'd63, 6, 12'd3969, 1'b0, 1'b1);
    @(negedge clk);
    chk("mul_busy_first", int'(busy), 1);
    start = 1'b1;
    func  = 2'b00;
    a     = 6'd1;
    b     = 6'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < e + 5) @(negedge clk);
    chk("mul_busy_last", int'(busy), 1);
    @(negedge clk);
    chk("mul_busy_end", int'(busy), 0);
    repeat (3) @(negedge clk);

    run("mul_0_63", 2'b10, 6'd0, 6'd63, 6, 12'd0, 1'b0);
`ifdef ALU_SEQ_DIV_EN
    run("div_45_7", 2'b11, 6'd45, 6'd7, 6, 12'd198, 1'b0);
    run("div_13_0", 2'b11, 6'd13, 6'd0, 0, 12'd895, 1'b1);
    run("div_63_1", 2'b11, 6'd63, 6'd1, 6, 12'd63, 1'b0);
`else
    run("div_45_7", 2'b11, 6'd45, 6'd7, 0, 12'd0, 1'b1);
    run("div_13_0", 2'b11, 6'd13, 6'd0, 0, 12'd0, 1'b1);
`endif

    // reset in the middle of mul 10x10
    @(negedge clk);
    send("mul_abort", 2'b10, 6'd10, 6'd10, 6, 12'd100, 1'b0, 1'b0);
    while (cyc < e + 3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_out", int'(out), 0);
    chk("abort_ovf", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    run("add_1_1", 2'b00, 6'd1, 6'd1, 0, 12'd2, 1'b0);

    // back-to-back: sub issued in the done cycle of mul
    @(negedge clk);
    send("mul_2_3", 2'b10, 6'd2, 6'd3, 6, 12'd6, 1'b0, 1'b1);
    while (cyc < e + 6) @(negedge clk);
    send("sub_7_3", 2'b01, 6'd7, 6'd3, 0, 12'd4, 1'b0, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
